// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: load/compute/unload handshake and RAM/ROM control bundle; FFT_SCALE_EN adds scale_shift
interface fft_sequencer_if #(
  parameter int LOG2N = 6,
  parameter int LVL_W = $clog2(LOG2N + 1)
);
  logic             load_valid, load_ready, ld_we;
  logic [LOG2N-1:0] ld_addr;
  logic             start, inverse, busy;
  logic             rd_en, rd_bank, wr_en, wr_bank, tw_conj;
  logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic [LVL_W-1:0] level;
  logic             out_valid, out_ready, out_bank, out_last, done;
  logic [LOG2N-1:0] out_addr;
`ifdef FFT_SCALE_EN
  logic             scale_shift;
`endif
  modport master (
    input  load_valid, start, inverse, out_ready,
    output load_ready, ld_we, ld_addr, busy, rd_en, rd_bank, rd_addr_a, rd_addr_b,
           wr_en, wr_bank, wr_addr_a, wr_addr_b, tw_addr, tw_conj, level,
           out_valid, out_bank, out_last, out_addr, done
`ifdef FFT_SCALE_EN
           , scale_shift
`endif
  );
  modport slave (
    output load_valid, start, inverse, out_ready,
    input  load_ready, ld_we, ld_addr, busy, rd_en, rd_bank, rd_addr_a, rd_addr_b,
           wr_en, wr_bank, wr_addr_a, wr_addr_b, tw_addr, tw_conj, level,
           out_valid, out_bank, out_last, out_addr, done
`ifdef FFT_SCALE_EN
           , scale_shift
`endif
  );
endinterface

// File: rtl/fft_sequencer.sv
// fft_sequencer: radix-2 DIT FFT load/compute/unload sequencer; FFT_SCALE_EN adds per-level scale_shift
module fft_sequencer #(
  parameter int LOG2N = 6,
  parameter int PIPE_LAT = 1,
  localparam int LVL_W = $clog2(LOG2N + 1)
) (
  input logic clk,
  input logic reset,
  fft_sequencer_if.master bus
);
  localparam int HW = LOG2N - 1;
  localparam int DW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, LOADED, RUN, DRAIN, UNLOAD} state_t;
  typedef struct packed {
    logic             en;
    logic             bank;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wr_t;
  state_t state, state_nx;
  logic [LOG2N-1:0] cnt, oaddr, iw, half, pos, addr_a, addr_b, bitrev;
  logic [HW-1:0] iter, twf;
  logic [DW-1:0] dcnt;
  logic [LVL_W-1:0] lvl;
  logic conj, run, ld_rdy, ld_hs, st_hs, out_hs, drain_end, lvl_end, done;
  wr_t rd_s;
  wr_t pipe [PIPE_LAT];
  assign run = state == RUN;
  assign ld_rdy = reset && (state == IDLE || state == LOAD);
  assign ld_hs = ld_rdy && bus.load_valid;
  assign st_hs = state == LOADED && bus.start;
  assign out_hs = state == UNLOAD && bus.out_ready;
  assign drain_end = dcnt == DW'(PIPE_LAT - 1);
  assign lvl_end = lvl == LVL_W'(LOG2N - 1);
  assign done = out_hs && &oaddr;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // next-state decisions, each taken on a terminal count
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = ld_hs ? LOAD : IDLE;
      LOAD:    state_nx = ld_hs && &cnt ? LOADED : LOAD;
      LOADED:  state_nx = bus.start ? RUN : LOADED;
      RUN:     state_nx = &iter ? DRAIN : RUN;
      DRAIN:   state_nx = !drain_end ? DRAIN : lvl_end ? UNLOAD : RUN;
      UNLOAD:  state_nx = done ? IDLE : UNLOAD;
      default: state_nx = IDLE;
    endcase
  end
  // sample, butterfly, drain, level and unload counters plus latched inverse flag
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      iter <= '0;
      dcnt <= '0;
      lvl <= '0;
      oaddr <= '0;
      conj <= 1'b0;
    end else begin
      cnt <= cnt + LOG2N'(ld_hs);
      iter <= run ? iter + HW'(1) : '0;
      dcnt <= state == DRAIN && !drain_end ? dcnt + DW'(1) : '0;
      lvl <= st_hs || done ? '0 : state == DRAIN && drain_end ? lvl + LVL_W'(1) : lvl;
      oaddr <= oaddr + LOG2N'(out_hs);
      conj <= st_hs ? bus.inverse : conj;
    end
  // butterfly operand / twiddle addressing and bit-reversed load address
  always_comb begin
    iw = {1'b0, iter};
    half = LOG2N'(1) << lvl;
    pos = iw & (half - LOG2N'(1));
    addr_a = ((iw >> lvl) << (lvl + LVL_W'(1))) | pos;
    addr_b = addr_a | half;
    twf = HW'(pos << (LVL_W'(HW) - lvl));
    rd_s.en = run;
    rd_s.bank = ~lvl[0];
    rd_s.a = run ? addr_a : '0;
    rd_s.b = run ? addr_b : '0;
    bitrev = '0;
    for (int k = 0; k < LOG2N; k++) bitrev[k] = cnt[LOG2N-1-k];
  end
  // write-back pipe: reads re-emerge PIPE_LAT cycles later, shifting on through DRAIN
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int k = 0; k < PIPE_LAT; k++) pipe[k] <= '0;
    else begin
      pipe[0] <= rd_s;
      for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
    end
  assign bus.load_ready = ld_rdy;
  assign bus.ld_we = ld_hs;
  assign bus.ld_addr = bitrev;
  assign bus.busy = run || state == DRAIN;
  assign bus.rd_en = run;
  assign bus.rd_bank = lvl[0];
  assign bus.rd_addr_a = rd_s.a;
  assign bus.rd_addr_b = rd_s.b;
  assign bus.tw_addr = run ? twf : '0;
  assign bus.tw_conj = conj;
  assign bus.level = lvl;
  assign bus.wr_en = pipe[PIPE_LAT-1].en;
  assign bus.wr_bank = pipe[PIPE_LAT-1].bank;
  assign bus.wr_addr_a = pipe[PIPE_LAT-1].a;
  assign bus.wr_addr_b = pipe[PIPE_LAT-1].b;
  assign bus.out_valid = state == UNLOAD;
  assign bus.out_addr = oaddr;
  assign bus.out_bank = 1'(LOG2N % 2);
  assign bus.out_last = state == UNLOAD && &oaddr;
  assign bus.done = done;
`ifdef FFT_SCALE_EN
  assign bus.scale_shift = pipe[PIPE_LAT-1].en;
`endif
endmodule
